// File: rtl/leiwand_rv32_wb_interconnect_pkg.sv
// Shared types and helpers for the single-master Wishbone interconnect.
package leiwand_rv32_wb_interconnect_pkg;

   // Bridge states: waiting for a request, tracking one outstanding
   // transaction, or answering an unmapped access with an error.
   typedef enum logic [1:0] {
      WB_IC_IDLE     = 2'd0,
      WB_IC_WAIT_ACK = 2'd1,
      WB_IC_ERR_RESP = 2'd2
   } wb_ic_state_t;

   // Index of the highest bit needed to hold value (value >= 1).
   function automatic int high_bit_to_fit(input int value);
      int bits;
      bits = 1;
      while ((value >> bits) != 0) begin
         bits++;
      end
      return bits - 1;
   endfunction

   // Width of an index that can address n items (at least one bit).
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/leiwand_rv32_wb_addr_decoder.sv
// Combinational address decoder: one-hot slave hit with lowest index winning.
module leiwand_rv32_wb_addr_decoder
   import leiwand_rv32_wb_interconnect_pkg::*;
#(
   parameter int MEM_WIDTH = 32,
   parameter int N_SLAVES  = 2,
   parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
   parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE = {32'h4000, 32'h4000}
) (
   input  logic [MEM_WIDTH-1:0] addr,
   output logic [N_SLAVES-1:0]  hit,
   output logic                 any_hit
);

   logic [N_SLAVES-1:0] raw_hit;
   logic [MEM_WIDTH:0]  addr_ext;

   assign addr_ext = {1'b0, addr};

   // Region bounds are computed one bit wider so a region ending exactly at
   // the top of the address space does not wrap to zero.
   for (genvar k = 0; k < N_SLAVES; k++) begin : g_region
      localparam logic [MEM_WIDTH:0] LO = {1'b0, SLAVE_BASE[k*MEM_WIDTH +: MEM_WIDTH]};
      localparam logic [MEM_WIDTH:0] HI = LO + {1'b0, SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH]};
      localparam bit EN = (SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH] != '0);
      assign raw_hit[k] = EN && (addr_ext >= LO) && (addr_ext < HI);
   end

   // Keep only the lowest-indexed matching region so overlaps resolve
   // deterministically and the result is strictly one-hot.
   always_comb begin
      hit     = '0;
      any_hit = 1'b0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (raw_hit[k] && !any_hit) begin
            hit[k]  = 1'b1;
            any_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone bridge with one outstanding
// transaction, per-slave response routing, unmapped-address errors and a
// timeout on slaves that never acknowledge.
module leiwand_rv32_wb_interconnect
   import leiwand_rv32_wb_interconnect_pkg::*;
#(
   parameter int MEM_WIDTH = 32,
   parameter int N_SLAVES  = 2,
   parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
   parameter logic [N_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE = {32'h4000, 32'h4000},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          m_cyc,
   input  logic                          m_stb,
   input  logic                          m_we,
   input  logic [MEM_WIDTH-1:0]          m_addr,
   input  logic [MEM_WIDTH-1:0]          m_data_out,
   output logic [MEM_WIDTH-1:0]          m_data_in,
   output logic                          m_ack,
   output logic                          m_err,
   output logic                          m_stall,
   output logic                          s_cyc,
   output logic                          s_we,
   output logic [MEM_WIDTH-1:0]          s_addr,
   output logic [MEM_WIDTH-1:0]          s_data_out,
   output logic [N_SLAVES-1:0]           s_stb,
   input  logic [N_SLAVES*MEM_WIDTH-1:0] s_data_in,
   input  logic [N_SLAVES-1:0]           s_ack,
   input  logic [N_SLAVES-1:0]           s_stall,
   output logic [MEM_WIDTH-1:0]          err_addr
);

   localparam int SEL_W = index_width(N_SLAVES);
   localparam int CNT_W = high_bit_to_fit(TIMEOUT_CYCLES) + 1;
   // The first WAIT_ACK cycle sees count 0, so the last allowed cycle is
   // TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   wb_ic_state_t         state, next_state;
   logic [SEL_W-1:0]     sel, next_sel;
   logic [CNT_W-1:0]     count, next_count;
   logic [MEM_WIDTH-1:0] req_addr, next_req_addr;
   logic [MEM_WIDTH-1:0] next_err_addr;

   logic [N_SLAVES-1:0]  hit;
   logic                 any_hit;
   logic [SEL_W-1:0]     hit_idx;

   assign s_cyc      = m_cyc;
   assign s_we       = m_we;
   assign s_addr     = m_addr;
   assign s_data_out = m_data_out;

   leiwand_rv32_wb_addr_decoder #(
      .MEM_WIDTH (MEM_WIDTH),
      .N_SLAVES  (N_SLAVES),
      .SLAVE_BASE(SLAVE_BASE),
      .SLAVE_SIZE(SLAVE_SIZE)
   ) u_decoder (
      .addr   (m_addr),
      .hit    (hit),
      .any_hit(any_hit)
   );

   // Turn the one-hot decoder output into a slave index for muxing.
   always_comb begin
      hit_idx = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (hit[k]) begin
            hit_idx = SEL_W'(k);
         end
      end
   end

   // State register plus the latched selection, timeout count, accepted
   // address and last error address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= WB_IC_IDLE;
         sel      <= '0;
         count    <= '0;
         req_addr <= '0;
         err_addr <= '0;
      end else begin
         state    <= next_state;
         sel      <= next_sel;
         count    <= next_count;
         req_addr <= next_req_addr;
         err_addr <= next_err_addr;
      end
   end

   // Next-state and master/slave handshake outputs; request decode and the
   // response path are combinational so no latency is added either way.
   always_comb begin
      next_state    = state;
      next_sel      = sel;
      next_count    = count;
      next_req_addr = req_addr;
      next_err_addr = err_addr;
      s_stb         = '0;
      m_stall       = 1'b0;
      m_ack         = 1'b0;
      m_err         = 1'b0;
      m_data_in     = '0;
      if (!reset) begin
         case (state)
            WB_IC_IDLE: begin
               if (m_cyc && m_stb) begin
                  if (any_hit) begin
                     s_stb   = hit;
                     m_stall = s_stall[hit_idx];
                     if (!s_stall[hit_idx]) begin
                        next_sel      = hit_idx;
                        next_count    = '0;
                        next_req_addr = m_addr;
                        next_state    = WB_IC_WAIT_ACK;
                     end
                  end else begin
                     next_err_addr = m_addr;
                     next_state    = WB_IC_ERR_RESP;
                  end
               end
            end
            WB_IC_WAIT_ACK: begin
               m_stall = 1'b1;
               if (!m_cyc) begin
                  next_state = WB_IC_IDLE;
               end else begin
                  m_data_in = s_data_in[sel*MEM_WIDTH +: MEM_WIDTH];
                  if (s_ack[sel]) begin
                     m_ack      = 1'b1;
                     next_state = WB_IC_IDLE;
                  end else if (count == CNT_LAST) begin
                     m_err         = 1'b1;
                     next_err_addr = req_addr;
                     next_state    = WB_IC_IDLE;
                  end else begin
                     next_count = count + 1'b1;
                  end
               end
            end
            WB_IC_ERR_RESP: begin
               m_stall    = 1'b1;
               m_err      = m_cyc;
               next_state = WB_IC_IDLE;
            end
            default: begin
               next_state = WB_IC_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Directed bench for the Wishbone interconnect with a response scoreboard.
module tb_leiwand_rv32_wb_interconnect;

   typedef struct packed {
      logic        is_err;
      logic [31:0] data;
   } resp_t;

   logic         clk;
   logic         reset;
   logic         m_cyc, m_stb, m_we;
   logic [31:0]  m_addr, m_data_out, m_data_in;
   logic         m_ack, m_err, m_stall;
   logic         s_cyc, s_we;
   logic [31:0]  s_addr, s_data_out;
   logic [3:0]   s_stb;
   logic [127:0] s_data_in;
   logic [3:0]   s_ack, s_stall;
   logic [31:0]  err_addr;
   logic [31:0]  sd [4];

   resp_t sb [$];
   int    vectors;
   int    miscompares;

   assign s_data_in = {sd[3], sd[2], sd[1], sd[0]};

   leiwand_rv32_wb_interconnect #(
      .MEM_WIDTH     (32),
      .N_SLAVES      (4),
      .SLAVE_BASE    ({32'hFFFFF000, 32'h10002000, 32'h20400000, 32'h10000000}),
      .SLAVE_SIZE    ({32'h00001000, 32'h00004000, 32'h00004000, 32'h00004000}),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .m_cyc     (m_cyc),
      .m_stb     (m_stb),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_data_out(m_data_out),
      .m_data_in (m_data_in),
      .m_ack     (m_ack),
      .m_err     (m_err),
      .m_stall   (m_stall),
      .s_cyc     (s_cyc),
      .s_we      (s_we),
      .s_addr    (s_addr),
      .s_data_out(s_data_out),
      .s_stb     (s_stb),
      .s_data_in (s_data_in),
      .s_ack     (s_ack),
      .s_stall   (s_stall),
      .err_addr  (err_addr)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      m_cyc      = cyc;
      m_stb      = stb;
      m_we       = we;
      m_addr     = addr;
      m_data_out = wdata;
   endtask

   // Move to the falling edge and retire any master response against the
   // oldest expected entry.
   task automatic sample();
      resp_t exp;
      @(negedge clk);
      if (m_ack || m_err) begin
         if (sb.size() == 0) begin
            checkOutput("sb_spurious", {30'b0, m_ack, m_err}, 32'h0);
         end else begin
            exp = sb.pop_front();
            checkOutput("sb_kind", {30'b0, m_ack, m_err}, exp.is_err ? 32'h1 : 32'h2);
            checkOutput("sb_data", m_data_in, exp.data);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   // One read accepted immediately and acked in the first wait cycle; every
   // slave acks with different data so only the selected one may be routed.
   task automatic singleRead(input string tag, input logic [31:0] addr,
                             input logic [3:0] exp_stb, input int slave, input logic [31:0] data);
      applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
      sample();
      checkOutput({tag, "_stb"}, 32'(s_stb), 32'(exp_stb));
      checkOutput({tag, "_stall"}, 32'(m_stall), 32'h0);
      sb.push_back(resp_t'{1'b0, data});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) sd[k] = data ^ 32'(k + 1);
      sd[slave] = data;
      s_ack = 4'b1111;
      sample();
      checkOutput({tag, "_ack"}, 32'(m_ack), 32'h1);
      advance();
      s_ack = 4'b0000;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      s_ack       = 4'b0000;
      s_stall     = 4'b0000;
      for (int k = 0; k < 4; k++) sd[k] = 32'h0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h10000000, 32'h0);
      advance();
      advance();

      // Outputs quiet during reset, broadcasts still follow the master
      sample();
      checkOutput("rst_s_stb", 32'(s_stb), 32'h0);
      checkOutput("rst_m_stall", 32'(m_stall), 32'h0);
      checkOutput("rst_m_ack", 32'(m_ack), 32'h0);
      checkOutput("rst_m_err", 32'(m_err), 32'h0);
      checkOutput("rst_m_data_in", m_data_in, 32'h0);
      checkOutput("rst_err_addr", err_addr, 32'h0);
      checkOutput("rst_s_cyc", 32'(s_cyc), 32'h1);
      checkOutput("rst_s_addr", s_addr, 32'h10000000);
      advance();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      advance();

      // Read ROM: slave1 acks in the second cycle after acceptance
      $display("[TB] read ROM");
      sd[0] = 32'h0BADF00D;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20400004, 32'h0);
      sample();
      checkOutput("rd_s_stb", 32'(s_stb), 32'h2);
      checkOutput("rd_stall", 32'(m_stall), 32'h0);
      checkOutput("rd_s_addr", s_addr, 32'h20400004);
      sb.push_back(resp_t'{1'b0, 32'hDEADBEEF});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("rd_wait_stb", 32'(s_stb), 32'h0);
      checkOutput("rd_wait_stall", 32'(m_stall), 32'h1);
      checkOutput("rd_wait_ack", 32'(m_ack), 32'h0);
      advance();
      sd[1] = 32'hDEADBEEF;
      s_ack = 4'b0010;
      sample();
      checkOutput("rd_ack", 32'(m_ack), 32'h1);
      checkOutput("rd_data", m_data_in, 32'hDEADBEEF);
      checkOutput("rd_err", 32'(m_err), 32'h0);
      advance();
      s_ack = 4'b0000;
      sd[1] = 32'h0;
      sample();
      checkOutput("rd_idle_ack", 32'(m_ack), 32'h0);
      checkOutput("rd_idle_data", m_data_in, 32'h0);
      checkOutput("rd_idle_stall", 32'(m_stall), 32'h0);
      advance();

      // Write SRAM: slave0 stalls three cycles, acks in the first wait cycle
      $display("[TB] write SRAM");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h10000008, 32'h12345678);
      s_stall = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         sample();
         checkOutput("wr_stall_stb", 32'(s_stb), 32'h1);
         checkOutput("wr_stall", 32'(m_stall), 32'h1);
         checkOutput("wr_s_data_out", s_data_out, 32'h12345678);
         checkOutput("wr_s_we", 32'(s_we), 32'h1);
         advance();
      end
      s_stall = 4'b0000;
      sample();
      checkOutput("wr_acc_stb", 32'(s_stb), 32'h1);
      checkOutput("wr_acc_stall", 32'(m_stall), 32'h0);
      sb.push_back(resp_t'{1'b0, 32'h0});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      sd[0] = 32'h0;
      s_ack = 4'b0001;
      sample();
      checkOutput("wr_ack", 32'(m_ack), 32'h1);
      advance();

      // Unmapped read issued back-to-back with the previous ack
      $display("[TB] unmapped");
      s_ack = 4'b0000;
      sd[0] = 32'hAAAA5555;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0);
      sample();
      checkOutput("um_stb", 32'(s_stb), 32'h0);
      checkOutput("um_stall", 32'(m_stall), 32'h0);
      checkOutput("um_acc_err", 32'(m_err), 32'h0);
      sb.push_back(resp_t'{1'b1, 32'h0});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("um_err", 32'(m_err), 32'h1);
      checkOutput("um_data", m_data_in, 32'h0);
      checkOutput("um_err_stall", 32'(m_stall), 32'h1);
      advance();
      sample();
      checkOutput("um_err_addr", err_addr, 32'h00000000);
      checkOutput("um_idle_err", 32'(m_err), 32'h0);
      advance();

      // One byte past the end of slave1 is unmapped
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20404000, 32'h0);
      sample();
      checkOutput("um2_stb", 32'(s_stb), 32'h0);
      sb.push_back(resp_t'{1'b1, 32'h0});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("um2_err", 32'(m_err), 32'h1);
      advance();
      sample();
      checkOutput("um2_err_addr", err_addr, 32'h20404000);
      advance();

      // Timeout: slave0 never acks while slave1 pulses spurious acks
      $display("[TB] timeout");
      sd[0] = 32'h0;
      sd[1] = 32'hFFFF0000;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h10000010, 32'h0);
      sample();
      checkOutput("to_stb", 32'(s_stb), 32'h1);
      sb.push_back(resp_t'{1'b1, 32'h0});
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         s_ack = (c == 2 || c == 5) ? 4'b0010 : 4'b0000;
         sample();
         checkOutput("to_ack", 32'(m_ack), 32'h0);
         checkOutput("to_err", 32'(m_err), (c == 8) ? 32'h1 : 32'h0);
         advance();
      end
      s_ack = 4'b0000;
      sample();
      checkOutput("to_err_addr", err_addr, 32'h10000010);
      checkOutput("to_idle_err", 32'(m_err), 32'h0);
      checkOutput("to_idle_stall", 32'(m_stall), 32'h0);
      advance();

      // Overlap resolves to slave0, just past it is slave2, top of space slave3
      $display("[TB] overlap and top of space");
      singleRead("ov", 32'h10002004, 4'b0001, 0, 32'h11111111);
      singleRead("ov2", 32'h10004000, 4'b0100, 2, 32'h33333333);
      singleRead("top", 32'hFFFFFFFC, 4'b1000, 3, 32'hCAFEF00D);

      // Abort: dropping m_cyc in WAIT_ACK gives no response, late ack ignored
      $display("[TB] abort");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h10000020, 32'h0);
      sample();
      checkOutput("ab_stb", 32'(s_stb), 32'h1);
      advance();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      checkOutput("ab_ack", 32'(m_ack), 32'h0);
      checkOutput("ab_err", 32'(m_err), 32'h0);
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      s_ack = 4'b0001;
      sample();
      checkOutput("ab_late_ack", 32'(m_ack), 32'h0);
      advance();
      s_ack = 4'b0000;

      // Reset in WAIT_ACK, then a fresh request completes normally
      $display("[TB] reset mid-transaction");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20400000, 32'h0);
      sample();
      checkOutput("rs_stb", 32'(s_stb), 32'h2);
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      sample();
      checkOutput("rs_during_stall", 32'(m_stall), 32'h0);
      checkOutput("rs_during_ack", 32'(m_ack), 32'h0);
      advance();
      reset = 1'b0;
      sd[1] = 32'h00000055;
      s_ack = 4'b0010;
      sample();
      checkOutput("rs_after_ack", 32'(m_ack), 32'h0);
      checkOutput("rs_after_stall", 32'(m_stall), 32'h0);
      checkOutput("rs_after_data", m_data_in, 32'h0);
      checkOutput("rs_err_addr", err_addr, 32'h0);
      advance();
      s_ack = 4'b0000;
      singleRead("rs_new", 32'h10000000, 4'b0001, 0, 32'h600DF00D);

      checkOutput("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
